// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder reusing one full_adder cell, LSB first, with a start/busy/done handshake
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fa_s, fa_cout, accept, run, last;
  full_adder u_fa (
    .A   (a_q[0]),
    .B   (b_q[0]),
    .Cin (carry_q),
    .S   (fa_s),
    .Cout(fa_cout)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = last ? DONE : RUN;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // start only counts outside RUN, so holding it high mid-add changes nothing
  always_comb begin
    run     = state_q == RUN;
    accept  = start && !run;
    last    = cnt_q == CW'(WIDTH - 1);
    a_d     = accept ? A : run ? a_q >> 1 : a_q;
    b_d     = accept ? B : run ? b_q >> 1 : b_q;
    carry_d = accept ? Cin : run ? fa_cout : carry_q;
    cnt_d   = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    s_d     = run ? (s_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1)) : s_q;
    cout_d  = (run && last) ? fa_cout : cout_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    busy = state_q == RUN;
    done = state_q == DONE;
    S    = s_q;
    Cout = cout_q;
  end
endmodule

module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: vector table, handshake corner cases and random adds against plain arithmetic
module tb_serial_add_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0, s;
  logic busy, done, cout;
  logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic busy1, done1, cout1;
  logic [0:0] s1;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Cin(cin),
    .busy(busy), .done(done), .S(s), .Cout(cout)
  );
  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Cin(cin1),
    .busy(busy1), .done(done1), .S(s1), .Cout(cout1)
  );

  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] s;
    logic       c;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_add(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                        output logic [7:0] rs, output logic rc, output int lat, output int bc);
    @(negedge clk);
    a = xa; b = xb; cin = xc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~xa; b = ~xb; cin = ~xc;
    lat = 0; bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      lat++;
      @(negedge clk);
    end
    rs = s; rc = cout;
  endtask

  initial begin
    logic [7:0] rs;
    logic rc;
    int lat, bc, n;
    logic [8:0] exp;
    logic [7:0] ra, rb;
    logic rcin;
    vecs[0] = '{8'h35, 8'h1C, 1'b0, 8'h51, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

    rst_n = 1'b0; start = 1'b1; start1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_s", 64'(s), 0);
    chk("rst_cout", 64'(cout), 0);
    chk("rst_w1", 64'({busy1, done1, s1, cout1}), 0);
    start = 1'b0; start1 = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", 64'({busy, done}), 0);

    for (int i = 0; i < 7; i++) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat, bc);
      chk($sformatf("vec%0d_s", i), 64'(rs), 64'(vecs[i].s));
      chk($sformatf("vec%0d_cout", i), 64'(rc), 64'(vecs[i].c));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 8);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 8);
    end
    @(negedge clk);
    chk("done_one_cycle", 64'({busy, done}), 0);

    // start held through RUN, A altered mid-run, then back-to-back from DONE
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    a = 8'hFF;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("hold_s", 64'(s), 8'h46);
    chk("hold_cout", 64'(cout), 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 40);
    chk("b2b_gap", 64'(n), 9);
    chk("b2b_s", 64'(s), 8'h33);
    chk("b2b_cout", 64'(cout), 1);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 64'({busy, done}), 0);

    // reset sampled on the 4th RUN edge
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 64'({busy, done, s, cout}), 0);
    rst_n = 1'b1;
    n = 0;
    repeat (12) begin @(negedge clk); if (done) n++; end
    chk("abort_no_done", 64'(n), 0);
    do_add(8'h80, 8'h80, 1'b0, rs, rc, lat, bc);
    chk("post_abort_sum", 64'({rc, rs}), 9'h100);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = i[2]; b1 = i[1]; cin1 = i[0]; start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 10) begin @(negedge clk); n++; end
      chk($sformatf("w1_%0d_latency", i), 64'(n), 1);
      chk($sformatf("w1_%0d_sum", i), 64'({cout1, s1}), 64'(i[2] + i[1] + i[0]));
    end

    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rcin = 1'($urandom);
      exp = 9'(ra) + 9'(rb) + 9'(rcin);
      do_add(ra, rb, rcin, rs, rc, lat, bc);
      chk($sformatf("rand%0d_%h_%h_%h", i, ra, rb, rcin), 64'({rc, rs}), 64'(exp));
      if (lat != 8) chk($sformatf("rand%0d_latency", i), 64'(lat), 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
